// File: rtl/pair_game_gen.sv
// Memory pair game: fetches LED pairs, flashes each one, then scores the player's
// switch guesses per pair, with lives, round growth and an external timeout.
module pair_game_gen #(
  parameter int unsigned SW_W         = 16,
  parameter int unsigned MAX_PAIRS    = 4,
  parameter int unsigned FLASH_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES   = 12_500_000,
  parameter int unsigned LIVES        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    bIn,
  input  logic [SW_W-1:0]         switchIn,
  input  logic                    gameTimeout,
  input  logic                    pairValid,
  input  logic [$clog2(SW_W)-1:0] pairA,
  input  logic [$clog2(SW_W)-1:0] pairB,
  output logic                    pairReq,
  output logic [SW_W-1:0]         redLight,
  output logic [MAX_PAIRS-1:0]    green,
  output logic [7:0]              score,
  output logic [3:0]              livesLeft,
  output logic [3:0]              roundPairs,
  output logic                    endGame,
  output logic                    timerEnable,
  output logic                    reconfig,
  output logic                    gameWait
);

  localparam int unsigned IDX_W   = $clog2(SW_W);
  localparam int unsigned CNT_MAX = (FLASH_CYCLES > GAP_CYCLES) ? FLASH_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    GAMEWAIT, INIT, FETCH, FLASH, GAP, GUESS, GAMEEND
  } state_t;

  state_t              state, state_n;
  logic [SW_W-1:0]     mask   [MAX_PAIRS];
  logic [SW_W-1:0]     mask_n [MAX_PAIRS];
  logic [3:0]          k, k_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [MAX_PAIRS-1:0] green_n;
  logic [7:0]          score_n;
  logic [3:0]          lives_n, rp_n;
  logic                end_n, pair_req_n, timer_n, wait_n;
  logic [SW_W-1:0]     red_n, cur_mask;
  logic                capture, timeout_hit;

  // One-hot LED bit for an index; indices beyond SW_W-1 contribute nothing.
  function automatic logic [SW_W-1:0] led_bit(input logic [IDX_W-1:0] idx);
    logic [SW_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(SW_W); i++)
      if (idx == IDX_W'(i)) m[i] = 1'b1;
    return m;
  endfunction

  always_comb begin
    cur_mask = '0;
    for (int i = 0; i < int'(MAX_PAIRS); i++)
      if (k == 4'(i)) cur_mask = mask[i];
  end

  assign timeout_hit = gameTimeout && (state inside {INIT, FETCH, FLASH, GAP, GUESS});

  // Next-state and next-value logic for every register.
  always_comb begin
    state_n = state;
    mask_n  = mask;
    k_n     = k;
    cnt_n   = cnt;
    green_n = green;
    score_n = score;
    lives_n = livesLeft;
    rp_n    = roundPairs;
    end_n   = endGame;
    capture = 1'b0;

    if (timeout_hit) begin
      state_n = GAMEEND;
    end else begin
      case (state)
        GAMEWAIT: if (bIn) begin
          state_n = INIT;
          score_n = 8'd0;
          lives_n = 4'(LIVES);
          rp_n    = 4'd1;
          end_n   = 1'b0;
        end
        INIT: begin
          green_n = '0;
          k_n     = 4'd0;
          state_n = FETCH;
        end
        FETCH: if (pairReq && pairValid) begin
          capture = 1'b1;
          for (int i = 0; i < int'(MAX_PAIRS); i++)
            if (k == 4'(i)) mask_n[i] = led_bit(pairA) | led_bit(pairB);
          if (k + 4'd1 >= roundPairs) begin
            k_n     = 4'd0;
            cnt_n   = '0;
            state_n = FLASH;
          end else begin
            k_n = k + 4'd1;
          end
        end
        FLASH: begin
          if (cnt == CW'(FLASH_CYCLES - 1)) begin
            cnt_n   = '0;
            state_n = GAP;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt_n = '0;
            if (k + 4'd1 < roundPairs) begin
              k_n     = k + 4'd1;
              state_n = FLASH;
            end else begin
              k_n     = 4'd0;
              state_n = GUESS;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        GUESS: if (bIn) begin
          if (switchIn == cur_mask) begin
            for (int i = 0; i < int'(MAX_PAIRS); i++)
              if (k == 4'(i)) green_n[i] = 1'b1;
            if (k + 4'd1 >= roundPairs) begin
              score_n = (score == 8'd255) ? score : score + 8'd1;
              rp_n    = (roundPairs < 4'(MAX_PAIRS)) ? roundPairs + 4'd1 : roundPairs;
              state_n = INIT;
            end else begin
              k_n = k + 4'd1;
            end
          end else if (livesLeft <= 4'd1) begin
            lives_n = 4'd0;
            state_n = GAMEEND;
          end else begin
            lives_n = livesLeft - 4'd1;
          end
        end
        GAMEEND: state_n = GAMEWAIT;
        default: state_n = GAMEWAIT;
      endcase
    end

    if (state_n == GAMEEND) end_n = 1'b1;

    // Registered outputs follow the state being entered.
    red_n = '0;
    if (state_n == FLASH)
      for (int i = 0; i < int'(MAX_PAIRS); i++)
        if (k_n == 4'(i)) red_n = mask_n[i];
    pair_req_n = (state_n == FETCH) && !capture;
    timer_n    = state_n inside {INIT, FETCH, FLASH, GAP, GUESS};
    wait_n     = (state_n == GAMEWAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= GAMEWAIT;
      mask        <= '{default: '0};
      k           <= 4'd0;
      cnt         <= '0;
      green       <= '0;
      score       <= 8'd0;
      livesLeft   <= 4'(LIVES);
      roundPairs  <= 4'd1;
      endGame     <= 1'b0;
      pairReq     <= 1'b0;
      redLight    <= '0;
      timerEnable <= 1'b0;
      reconfig    <= 1'b0;
      gameWait    <= 1'b1;
    end else if (enable) begin
      state       <= state_n;
      mask        <= mask_n;
      k           <= k_n;
      cnt         <= cnt_n;
      green       <= green_n;
      score       <= score_n;
      livesLeft   <= lives_n;
      roundPairs  <= rp_n;
      endGame     <= end_n;
      pairReq     <= pair_req_n;
      redLight    <= red_n;
      timerEnable <= timer_n;
      reconfig    <= wait_n;
      gameWait    <= wait_n;
    end
  end

endmodule

// File: tb/tb_pair_game_gen.sv
// Directed bench for pair_game_gen: a pair source feeds a queue of expected flash
// masks which a redLight monitor pops and checks, plus directed status checks.
module tb_pair_game_gen;

  localparam int unsigned SW_W = 16, MAX_PAIRS = 3, FLASH_CYCLES = 4, GAP_CYCLES = 2, LIVES = 2;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] m;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst, enable, bIn, gameTimeout;
  logic        pairValid = 1'b0;
  logic [15:0] switchIn;
  logic [3:0]  pairA = 4'd0, pairB = 4'd0;
  logic        pairReq, endGame, timerEnable, reconfig, gameWait;
  logic [15:0] redLight;
  logic [2:0]  green;
  logic [7:0]  score;
  logic [3:0]  livesLeft, roundPairs;

  int n_assert = 0, n_fail = 0;
  int flashes = 0, run_len = 0;
  logic [15:0] prev_red = 16'h0;
  logic [15:0] saved;
  pair_t       src_q[$];
  logic [15:0] exp_q[$];

  pair_game_gen #(
    .SW_W(SW_W), .MAX_PAIRS(MAX_PAIRS), .FLASH_CYCLES(FLASH_CYCLES),
    .GAP_CYCLES(GAP_CYCLES), .LIVES(LIVES)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .bIn(bIn), .switchIn(switchIn),
    .gameTimeout(gameTimeout), .pairValid(pairValid), .pairA(pairA), .pairB(pairB),
    .pairReq(pairReq), .redLight(redLight), .green(green), .score(score),
    .livesLeft(livesLeft), .roundPairs(roundPairs), .endGame(endGame),
    .timerEnable(timerEnable), .reconfig(reconfig), .gameWait(gameWait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [15:0] sw);
    switchIn = sw;
    bIn = 1'b1;
    step();
    bIn = 1'b0;
  endtask

  task automatic wait_flashes(input int n);
    int i;
    i = 0;
    while (flashes < n && i < 300) begin
      step();
      i++;
    end
    chk("flash_count", 32'(flashes), 32'(n));
    repeat (3) step();
  endtask

  // Pair source: presents the next pair while pairReq is high, holds it until taken.
  always @(posedge clk) begin : source
    pair_t p;
    #1;
    if (pairValid) begin
      if (!pairReq) pairValid = 1'b0;
    end else if (pairReq && src_q.size() > 0) begin
      p = src_q.pop_front();
      pairA = p.a;
      pairB = p.b;
      pairValid = 1'b1;
      exp_q.push_back(p.m);
    end
  end

  // Flash monitor: value and enabled-cycle length of each lit period.
  always @(negedge clk) begin
    if (prev_red != 16'h0 && redLight != prev_red) begin
      if (exp_q.size() == 0) chk("flash_unexpected", 32'(prev_red), 32'h0);
      else chk("flash_value", 32'(prev_red), 32'(exp_q.pop_front()));
      chk("flash_len", 32'(run_len), 32'(FLASH_CYCLES));
      run_len = 0;
      flashes++;
    end
    if (redLight != 16'h0 && enable) run_len++;
    prev_red = redLight;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; bIn = 1'b0; gameTimeout = 1'b0; switchIn = 16'h0;
    step(); step();
    chk("rst_gameWait", 32'(gameWait), 32'd1);
    chk("rst_reconfig", 32'(reconfig), 32'd0);
    chk("rst_pairReq", 32'(pairReq), 32'd0);
    chk("rst_redLight", 32'(redLight), 32'd0);
    chk("rst_green", 32'(green), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_lives", 32'(livesLeft), 32'd2);
    chk("rst_roundPairs", 32'(roundPairs), 32'd1);
    chk("rst_endGame", 32'(endGame), 32'd0);
    chk("rst_timerEnable", 32'(timerEnable), 32'd0);
    rst = 1'b0;
    step();
    chk("wait_reconfig", 32'(reconfig), 32'd1);
    chk("wait_gameWait", 32'(gameWait), 32'd1);

    // Round 1
    src_q.push_back('{4'd2, 4'd9, 16'h0204});
    press(16'h0);
    chk("init_gameWait", 32'(gameWait), 32'd0);
    chk("init_timerEnable", 32'(timerEnable), 32'd1);
    chk("init_lives", 32'(livesLeft), 32'd2);
    step();
    chk("fetch_pairReq", 32'(pairReq), 32'd1);
    wait_flashes(1);
    src_q.push_back('{4'd0, 4'd15, 16'h8001});
    src_q.push_back('{4'd3, 4'd3, 16'h0008});
    press(16'h0204);
    chk("r1_green", 32'(green), 32'h1);
    chk("r1_score", 32'(score), 32'd1);
    chk("r1_roundPairs", 32'(roundPairs), 32'd2);

    // Round 2
    wait_flashes(3);
    press(16'h8001);
    chk("r2_green_partial", 32'(green), 32'h1);
    chk("r2_score_partial", 32'(score), 32'd1);
    src_q.push_back('{4'd1, 4'd2, 16'h0006});
    src_q.push_back('{4'd4, 4'd5, 16'h0030});
    src_q.push_back('{4'd6, 4'd6, 16'h0040});
    press(16'h0008);
    chk("r2_green", 32'(green), 32'h3);
    chk("r2_score", 32'(score), 32'd2);
    chk("r2_roundPairs", 32'(roundPairs), 32'd3);

    // Round 3: roundPairs saturates at MAX_PAIRS
    wait_flashes(6);
    press(16'h0006);
    press(16'h0030);
    src_q.push_back('{4'd7, 4'd8, 16'h0180});
    src_q.push_back('{4'd10, 4'd11, 16'h0C00});
    src_q.push_back('{4'd12, 4'd13, 16'h3000});
    press(16'h0040);
    chk("r3_green", 32'(green), 32'h7);
    chk("r3_score", 32'(score), 32'd3);
    chk("r3_roundPairs", 32'(roundPairs), 32'd3);

    // Round 4: freeze during the first flash
    for (int i = 0; i < 100 && redLight == 16'h0; i++) step();
    saved = redLight;
    chk("freeze_start", 32'(saved), 32'h0180);
    enable = 1'b0;
    repeat (10) step();
    chk("freeze_redLight", 32'(redLight), 32'(saved));
    enable = 1'b1;
    wait_flashes(9);

    // Two wrong guesses exhaust the lives
    press(16'h0001);
    chk("miss1_lives", 32'(livesLeft), 32'd1);
    chk("miss1_green", 32'(green), 32'h0);
    press(16'h0001);
    chk("miss2_lives", 32'(livesLeft), 32'd0);
    chk("end_endGame", 32'(endGame), 32'd1);
    chk("end_timerEnable", 32'(timerEnable), 32'd0);
    chk("end_gameWait", 32'(gameWait), 32'd0);
    step();
    chk("end_back_wait", 32'(gameWait), 32'd1);
    chk("end_score_held", 32'(score), 32'd3);
    chk("end_endGame_held", 32'(endGame), 32'd1);

    // Timeout wins over a simultaneous correct guess
    src_q.push_back('{4'd5, 4'd14, 16'h4020});
    press(16'h0);
    chk("g2_endGame_clr", 32'(endGame), 32'd0);
    chk("g2_score", 32'(score), 32'd0);
    chk("g2_lives", 32'(livesLeft), 32'd2);
    wait_flashes(10);
    switchIn = 16'h4020; bIn = 1'b1; gameTimeout = 1'b1;
    step();
    bIn = 1'b0; gameTimeout = 1'b0;
    chk("to_green", 32'(green), 32'h0);
    chk("to_score", 32'(score), 32'd0);
    chk("to_endGame", 32'(endGame), 32'd1);
    chk("to_timerEnable", 32'(timerEnable), 32'd0);
    step();
    chk("to_gameWait", 32'(gameWait), 32'd1);

    // Asynchronous reset while requesting a pair
    press(16'h0);
    step();
    chk("ar_pairReq_before", 32'(pairReq), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("ar_pairReq", 32'(pairReq), 32'd0);
    chk("ar_gameWait", 32'(gameWait), 32'd1);
    chk("ar_timerEnable", 32'(timerEnable), 32'd0);
    chk("ar_reconfig", 32'(reconfig), 32'd0);
    chk("ar_roundPairs", 32'(roundPairs), 32'd1);
    chk("ar_redLight", 32'(redLight), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("ar_resume_wait", 32'(gameWait), 32'd1);
    chk("ar_resume_reconfig", 32'(reconfig), 32'd1);
    chk("ar_resume_pairReq", 32'(pairReq), 32'd0);
    chk("ar_no_capture", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pair_game_gen.md
PAIR_GAME_GEN -- requirements
Module: pair_game_gen

Interface
REQ-001 SHALL have parameter SW_W, 16, width of switchIn/redLight (>=2).
REQ-002 SHALL have parameter MAX_PAIRS, 4, maximum pairs per round (1..8).
REQ-003 SHALL have parameter FLASH_CYCLES, 50_000_000, clk cycles each pair is lit (>=1).
REQ-004 SHALL have parameter GAP_CYCLES, 12_500_000, dark clk cycles after each flash (>=1).
REQ-005 SHALL have parameter LIVES, 3, wrong guesses allowed per game (1..15).
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 enable  in  1  high: FSM and counters advance; low: all state held.
REQ-009 bIn  in  1  one-cycle debounced button pulse (start/submit).
REQ-010 switchIn  in  SW_W  player guess.
REQ-011 gameTimeout  in  1  external game timer expired.
REQ-012 pairValid  in  1  pair source has pairA/pairB ready.
REQ-013 pairA, pairB  in  $clog2(SW_W) each  LED indices of one pair.
REQ-014 pairReq  out  1  request for next pair.
REQ-015 redLight  out  SW_W  flash display.
REQ-016 green  out  MAX_PAIRS  per-pair solved flags.
REQ-017 score  out  8  rounds completed, saturating at 255.
REQ-018 livesLeft  out  4  remaining lives.
REQ-019 roundPairs  out  4  pairs in current round.
REQ-020 endGame, timerEnable, reconfig, gameWait  out  1 each  status/control to timer and display.

Function
REQ-021 FSM states SHALL be GAMEWAIT, INIT, FETCH, FLASH, GAP, GUESS, GAMEEND; all transitions gated by enable.
REQ-022 GAMEWAIT: gameWait=1, reconfig=1, timerEnable=0; bIn -> INIT with score=0, livesLeft=LIVES, roundPairs=1, endGame=0.
REQ-023 INIT (1 cycle): gameWait=0, reconfig=0, timerEnable=1, green=0, slot index k=0 -> FETCH.
REQ-024 FETCH: pairReq=1 until cycle where pairValid=1; that cycle mask[k] = (1<<pairA)|(1<<pairB) (single bit if pairA==pairB), k++, pairReq drops next cycle; after roundPairs captures -> FLASH with k=0.
REQ-025 Out-of-range index (>=SW_W) SHALL be masked to zero contribution; such a pair's mask may be zero.
REQ-026 FLASH: redLight=mask[k] for exactly FLASH_CYCLES cycles, then GAP.
REQ-027 GAP: redLight=0 for exactly GAP_CYCLES cycles; then k++ -> FLASH if k<roundPairs, else k=0 -> GUESS.
REQ-028 GUESS: on bIn, switchIn==mask[k] -> green[k]=1, k++; mismatch -> livesLeft-1, k unchanged; no bIn -> hold.
REQ-029 Mismatch with livesLeft==1 SHALL decrement to 0 and go to GAMEEND.
REQ-030 Last pair matched -> score+1 (saturate 255), roundPairs=min(roundPairs+1, MAX_PAIRS), -> INIT.
REQ-031 gameTimeout in INIT/FETCH/FLASH/GAP/GUESS -> GAMEEND next cycle, overriding simultaneous bIn or pairValid (pair not consumed, pairReq dropped).
REQ-032 GAMEEND (1 cycle): timerEnable=0, redLight=0, pairReq=0, endGame=1 -> GAMEWAIT; endGame stays 1 until next INIT; score, green, livesLeft hold.
REQ-033 enable low SHALL freeze state, counters and all outputs; pulses (bIn, pairValid, gameTimeout) while enable low are ignored.
REQ-034 Flash/gap counters SHALL be sized $clog2(max(FLASH_CYCLES,GAP_CYCLES)+1) and reset to 0 on each state entry.

Reset
REQ-035 On rst: state=GAMEWAIT, redLight=0, green=0, score=0, livesLeft=LIVES, roundPairs=1, pairReq=0, endGame=0, timerEnable=0, reconfig=0, gameWait=1, masks=0, counters=0.
REQ-036 rst asserted mid-round SHALL abort immediately (asynchronously) with values of REQ-035; release resumes in GAMEWAIT.

Verification (SW_W=16, MAX_PAIRS=3, FLASH_CYCLES=4, GAP_CYCLES=2, LIVES=2)
REQ-037 bIn in GAMEWAIT, source supplies (2,9) -> pairReq 1 until capture, redLight=0x0204 for 4 cycles, 0 for 2, then GUESS; switchIn=0x0204+bIn -> green=001, score=1, roundPairs=2.
REQ-038 Round 2 pairs (0,15),(3,3) -> flashes 0x8001 then 0x0008; guesses 0x8001, 0x0008 -> green=011, score=2, roundPairs=3; round 3 win -> score=3, roundPairs stays 3.
REQ-039 GUESS wrong 0x0001 twice -> livesLeft 2->1->0, GAMEEND one cycle, endGame=1, timerEnable=0, then GAMEWAIT with score held.
REQ-040 gameTimeout and bIn (correct guess) same cycle -> GAMEEND, green unchanged, score unchanged.
REQ-041 enable low for 10 cycles mid-FLASH -> redLight and counter frozen; flash totals exactly 4 enabled cycles.
REQ-042 rst pulse during FETCH with pairReq=1 -> pairReq=0, gameWait=1, all REQ-035 values same edge, no pair captured.
